// File: rtl/commit_unit.sv
// ============================================================================
// commit_unit : in-order retirement of the ROB head (ALU/load writeback,
//               store handshake, branch mispredict redirect and flush).
// Revision    : 1.0
// ============================================================================
`default_nettype none

module commit_unit #(
  parameter int FLUSH_CYCLES = 2,
  parameter int ROB_IDX_W    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rob_head_valid,
  input  logic                 rob_head_ready,
  input  logic [1:0]           rob_head_itype,
  input  logic [4:0]           rob_head_dest,
  input  logic [31:0]          rob_head_value,
  input  logic [31:0]          rob_head_addr,
  input  logic [ROB_IDX_W-1:0] rob_head_num,
  input  logic [31:0]          rob_head_pc,
  input  logic                 rob_head_taken,
  input  logic                 rob_head_pred,
  input  logic [31:0]          rob_head_target,
  input  logic                 mem_ack,
  output logic                 rob_rd_en,
  output logic                 rf_we,
  output logic [4:0]           rf_waddr,
  output logic [31:0]          rf_wdata,
  output logic [ROB_IDX_W-1:0] rf_wrob,
  output logic                 mem_req,
  output logic [31:0]          mem_addr,
  output logic [31:0]          mem_wdata,
  output logic                 redirect_valid,
  output logic [31:0]          redirect_pc,
  output logic                 flush,
  output logic [31:0]          commit_count
);

  localparam logic [1:0] C_ITYPE_BRANCH = 2'b00;
  localparam logic [1:0] C_ITYPE_STORE  = 2'b01;
  localparam logic [3:0] C_FLUSH_LAST   = 4'(FLUSH_CYCLES - 1);

  typedef enum logic [1:0] {
    S_RUN     = 2'd0,
    S_ST_WAIT = 2'd1,
    S_FLUSH   = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [3:0]             flush_cnt_q, flush_cnt_d;
  logic                   rf_we_q, rf_we_d;
  logic [4:0]             rf_waddr_q, rf_waddr_d;
  logic [31:0]            rf_wdata_q, rf_wdata_d;
  logic [ROB_IDX_W-1:0]   rf_wrob_q, rf_wrob_d;
  logic                   mem_req_q, mem_req_d;
  logic [31:0]            mem_addr_q, mem_addr_d;
  logic [31:0]            mem_wdata_q, mem_wdata_d;
  logic                   redirect_valid_q, redirect_valid_d;
  logic [31:0]            redirect_pc_q, redirect_pc_d;
  logic                   flush_q, flush_d;
  logic [31:0]            commit_count_q, commit_count_d;
  logic                   w_eligible;

  assign w_eligible = rob_head_valid & rob_head_ready;

  always_comb begin
    state_d          = state_q;
    flush_cnt_d      = flush_cnt_q;
    rf_we_d          = 1'b0;
    rf_waddr_d       = rf_waddr_q;
    rf_wdata_d       = rf_wdata_q;
    rf_wrob_d        = rf_wrob_q;
    mem_req_d        = mem_req_q;
    mem_addr_d       = mem_addr_q;
    mem_wdata_d      = mem_wdata_q;
    redirect_valid_d = 1'b0;
    redirect_pc_d    = redirect_pc_q;
    flush_d          = flush_q;
    commit_count_d   = commit_count_q;
    rob_rd_en        = 1'b0;

    case (state_q)
      S_RUN: begin
        if (w_eligible) begin
          case (rob_head_itype)
            C_ITYPE_BRANCH: begin
              rob_rd_en = 1'b1;
              if (rob_head_taken != rob_head_pred) begin
                redirect_valid_d = 1'b1;
                redirect_pc_d    = rob_head_taken ? rob_head_target
                                                  : rob_head_pc + 32'd4;
                flush_d          = 1'b1;
                flush_cnt_d      = C_FLUSH_LAST;
                state_d          = S_FLUSH;
              end
            end
            C_ITYPE_STORE: begin
              // The store stays at the head until memory accepts it.
              mem_req_d   = 1'b1;
              mem_addr_d  = rob_head_addr;
              mem_wdata_d = rob_head_value;
              state_d     = S_ST_WAIT;
            end
            default: begin
              rob_rd_en  = 1'b1;
              rf_we_d    = (rob_head_dest != 5'd0);
              rf_waddr_d = rob_head_dest;
              rf_wdata_d = rob_head_value;
              rf_wrob_d  = rob_head_num;
            end
          endcase
        end
      end
      S_ST_WAIT: begin
        if (mem_ack) begin
          rob_rd_en = 1'b1;
          mem_req_d = 1'b0;
          state_d   = S_RUN;
        end
      end
      S_FLUSH: begin
        // flush_cnt_q counts the flush cycles still to come after this one.
        if (flush_cnt_q == 4'd0) begin
          flush_d = 1'b0;
          state_d = S_RUN;
        end else begin
          flush_cnt_d = flush_cnt_q - 4'd1;
        end
      end
      default: begin
        state_d   = S_RUN;
        flush_d   = 1'b0;
        mem_req_d = 1'b0;
      end
    endcase

    if (rob_rd_en) begin
      commit_count_d = commit_count_q + 32'd1;
    end

    if (reset) begin
      rob_rd_en = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= S_RUN;
      flush_cnt_q      <= 4'd0;
      rf_we_q          <= 1'b0;
      rf_waddr_q       <= 5'd0;
      rf_wdata_q       <= 32'd0;
      rf_wrob_q        <= '0;
      mem_req_q        <= 1'b0;
      mem_addr_q       <= 32'd0;
      mem_wdata_q      <= 32'd0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
      flush_q          <= 1'b0;
      commit_count_q   <= 32'd0;
    end else begin
      state_q          <= state_d;
      flush_cnt_q      <= flush_cnt_d;
      rf_we_q          <= rf_we_d;
      rf_waddr_q       <= rf_waddr_d;
      rf_wdata_q       <= rf_wdata_d;
      rf_wrob_q        <= rf_wrob_d;
      mem_req_q        <= mem_req_d;
      mem_addr_q       <= mem_addr_d;
      mem_wdata_q      <= mem_wdata_d;
      redirect_valid_q <= redirect_valid_d;
      redirect_pc_q    <= redirect_pc_d;
      flush_q          <= flush_d;
      commit_count_q   <= commit_count_d;
    end
  end

  assign rf_we          = rf_we_q;
  assign rf_waddr       = rf_waddr_q;
  assign rf_wdata       = rf_wdata_q;
  assign rf_wrob        = rf_wrob_q;
  assign mem_req        = mem_req_q;
  assign mem_addr       = mem_addr_q;
  assign mem_wdata      = mem_wdata_q;
  assign redirect_valid = redirect_valid_q;
  assign redirect_pc    = redirect_pc_q;
  assign flush          = flush_q;
  assign commit_count   = commit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_commit_unit.sv
// ============================================================================
// tb_commit_unit : vector table, directed corner sequences and random
//                  stimulus against a rule-level retirement model.
// Revision       : 1.0
// ============================================================================
`default_nettype none

module tb_commit_unit;

  localparam int FC = 2;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          rob_head_valid, rob_head_ready;
  logic [1:0]    rob_head_itype;
  logic [4:0]    rob_head_dest;
  logic [31:0]   rob_head_value, rob_head_addr, rob_head_pc, rob_head_target;
  logic [RW-1:0] rob_head_num;
  logic          rob_head_taken, rob_head_pred, mem_ack;
  logic          rob_rd_en, rf_we, mem_req, redirect_valid, flush;
  logic [4:0]    rf_waddr;
  logic [31:0]   rf_wdata, mem_addr, mem_wdata, redirect_pc, commit_count;
  logic [RW-1:0] rf_wrob;

  always #5 clk = ~clk;

  commit_unit #(.FLUSH_CYCLES(FC), .ROB_IDX_W(RW)) dut (
    .clk(clk), .reset(reset),
    .rob_head_valid(rob_head_valid), .rob_head_ready(rob_head_ready),
    .rob_head_itype(rob_head_itype), .rob_head_dest(rob_head_dest),
    .rob_head_value(rob_head_value), .rob_head_addr(rob_head_addr),
    .rob_head_num(rob_head_num), .rob_head_pc(rob_head_pc),
    .rob_head_taken(rob_head_taken), .rob_head_pred(rob_head_pred),
    .rob_head_target(rob_head_target), .mem_ack(mem_ack),
    .rob_rd_en(rob_rd_en), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .rf_wrob(rf_wrob), .mem_req(mem_req),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .flush(flush), .commit_count(commit_count)
  );

  int nvec = 0;
  int nmis = 0;

  // Reference model: a pending-store flag and a count of flush cycles left.
  bit            m_store = 0;
  int            m_flush_left = 0;
  logic          m_rf_we = 0, m_mem_req = 0, m_redir = 0, m_flush = 0;
  logic [4:0]    m_waddr = 0;
  logic [31:0]   m_wdata = 0, m_maddr = 0, m_mdata = 0, m_rpc = 0, m_count = 0;
  logic [RW-1:0] m_wrob = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nmis++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic model_rd_en();
    if (reset) return 1'b0;
    if (m_flush_left > 0) return 1'b0;
    if (m_store) return mem_ack;
    return rob_head_valid && rob_head_ready && (rob_head_itype != 2'b01);
  endfunction

  function automatic void model_update();
    logic rd;
    if (reset) begin
      m_store = 0; m_flush_left = 0;
      m_rf_we = 0; m_mem_req = 0; m_redir = 0; m_flush = 0;
      m_waddr = 0; m_wdata = 0; m_wrob = 0; m_maddr = 0; m_mdata = 0;
      m_rpc = 0; m_count = 0;
      return;
    end
    rd = model_rd_en();
    m_rf_we = 0;
    m_redir = 0;
    if (rd) m_count = m_count + 1;
    if (m_flush_left > 0) begin
      m_flush_left--;
    end else if (m_store) begin
      if (mem_ack) begin
        m_store = 0;
        m_mem_req = 0;
      end
    end else if (rob_head_valid && rob_head_ready) begin
      case (rob_head_itype)
        2'b00: if (rob_head_taken != rob_head_pred) begin
          m_redir = 1;
          m_rpc = rob_head_taken ? rob_head_target : rob_head_pc + 32'd4;
          m_flush_left = FC;
        end
        2'b01: begin
          m_store = 1; m_mem_req = 1;
          m_maddr = rob_head_addr; m_mdata = rob_head_value;
        end
        default: begin
          m_rf_we = (rob_head_dest != 0);
          m_waddr = rob_head_dest; m_wdata = rob_head_value; m_wrob = rob_head_num;
        end
      endcase
    end
    m_flush = (m_flush_left > 0);
  endfunction

  function automatic void check_regs();
    chk("rf_we", rf_we, m_rf_we);
    chk("mem_req", mem_req, m_mem_req);
    chk("redirect_valid", redirect_valid, m_redir);
    chk("flush", flush, m_flush);
    chk("commit_count", commit_count, m_count);
    if (m_rf_we) begin
      chk("rf_waddr", rf_waddr, m_waddr);
      chk("rf_wdata", rf_wdata, m_wdata);
      chk("rf_wrob", rf_wrob, m_wrob);
    end
    if (m_mem_req) begin
      chk("mem_addr", mem_addr, m_maddr);
      chk("mem_wdata", mem_wdata, m_mdata);
    end
    if (m_redir) chk("redirect_pc", redirect_pc, m_rpc);
  endfunction

  // Inputs are set by the caller; exp_rd < 0 means no fixed expectation.
  task automatic step(input int exp_rd);
    #1;
    chk("rob_rd_en", rob_rd_en, model_rd_en());
    if (exp_rd >= 0) chk("rob_rd_en_dir", rob_rd_en, exp_rd[0]);
    @(posedge clk);
    model_update();
    #1;
    check_regs();
  endtask

  task automatic head(input logic [1:0] it, input logic [4:0] d, input logic [31:0] v,
                      input logic [31:0] a, input logic [31:0] pc, input logic tk,
                      input logic pr, input logic [31:0] tg);
    rob_head_valid = 1; rob_head_ready = 1; rob_head_itype = it;
    rob_head_dest = d; rob_head_value = v; rob_head_addr = a; rob_head_pc = pc;
    rob_head_taken = tk; rob_head_pred = pr; rob_head_target = tg;
    rob_head_num = RW'(d);
  endtask

  task automatic idle(input int n);
    rob_head_valid = 0; mem_ack = 0;
    repeat (n) step(-1);
  endtask

  typedef struct {
    logic [1:0]  itype;
    logic        ready;
    logic [4:0]  dest;
    logic [31:0] value;
    logic [31:0] pc;
    logic        taken;
    logic        pred;
    logic [31:0] target;
    logic        exp_rd;
    logic        exp_we;
    logic        exp_redir;
    logic [31:0] exp_rpc;
    logic        exp_flush;
  } vec_t;

  vec_t vecs[8];

  initial begin
    vecs[0] = '{2'b10, 1, 5'd5,  32'hDEADBEEF, 32'h0,        0, 0, 32'h0,    1, 1, 0, 32'h0,    0};
    vecs[1] = '{2'b11, 1, 5'd0,  32'h12345678, 32'h0,        0, 0, 32'h0,    1, 0, 0, 32'h0,    0};
    vecs[2] = '{2'b10, 0, 5'd7,  32'h00000001, 32'h0,        0, 0, 32'h0,    0, 0, 0, 32'h0,    0};
    vecs[3] = '{2'b00, 1, 5'd0,  32'h0,        32'h80,       1, 1, 32'h200,  1, 0, 0, 32'h0,    0};
    vecs[4] = '{2'b00, 1, 5'd0,  32'h0,        32'h40,       0, 1, 32'h300,  1, 0, 1, 32'h44,   1};
    vecs[5] = '{2'b00, 1, 5'd0,  32'h0,        32'hFFFFFFFC, 0, 1, 32'h10,   1, 0, 1, 32'h0,    1};
    vecs[6] = '{2'b00, 1, 5'd0,  32'h0,        32'h500,      1, 0, 32'h1234, 1, 0, 1, 32'h1234, 1};
    vecs[7] = '{2'b11, 1, 5'd31, 32'hCAFEF00D, 32'h0,        0, 0, 32'h0,    1, 1, 0, 32'h0,    0};

    // Reset with an eligible ALU head present: nothing may dequeue.
    head(2'b10, 5'd9, 32'h11, 32'h0, 32'h0, 0, 0, 32'h0);
    mem_ack = 1;
    reset = 1;
    step(0);
    step(0);
    chk("rst_rf_waddr", rf_waddr, 0);
    chk("rst_rf_wdata", rf_wdata, 0);
    chk("rst_rf_wrob", rf_wrob, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_wdata", mem_wdata, 0);
    chk("rst_redirect_pc", redirect_pc, 0);
    chk("rst_count", commit_count, 0);
    reset = 0;
    idle(1);

    for (int i = 0; i < 8; i++) begin
      head(vecs[i].itype, vecs[i].dest, vecs[i].value, 32'h0, vecs[i].pc,
           vecs[i].taken, vecs[i].pred, vecs[i].target);
      rob_head_ready = vecs[i].ready;
      step(int'(vecs[i].exp_rd));
      chk("vec_rf_we", rf_we, vecs[i].exp_we);
      if (vecs[i].exp_we) begin
        chk("vec_rf_waddr", rf_waddr, vecs[i].dest);
        chk("vec_rf_wdata", rf_wdata, vecs[i].value);
      end
      chk("vec_redirect", redirect_valid, vecs[i].exp_redir);
      if (vecs[i].exp_redir) chk("vec_redirect_pc", redirect_pc, vecs[i].exp_rpc);
      chk("vec_flush", flush, vecs[i].exp_flush);
      idle(FC + 1);
    end

    // Store with ack on the third mem_req cycle; head changes meanwhile.
    mem_ack = 0;
    head(2'b01, 5'd0, 32'h55, 32'h100, 32'h0, 0, 0, 32'h0);
    step(0);
    head(2'b10, 5'd3, 32'h99, 32'hABC, 32'h0, 0, 0, 32'h0);
    for (int c = 0; c < 3; c++) begin
      chk("st_mem_req", mem_req, 1);
      chk("st_mem_addr", mem_addr, 32'h100);
      chk("st_mem_wdata", mem_wdata, 32'h55);
      chk("st_rf_we", rf_we, 0);
      mem_ack = (c == 2);
      step(c == 2 ? 1 : 0);
    end
    chk("st_done_req", mem_req, 0);
    idle(1);

    // Ack in the very cycle mem_req first rises.
    head(2'b01, 5'd0, 32'h77, 32'h200, 32'h0, 0, 0, 32'h0);
    step(0);
    rob_head_valid = 0; mem_ack = 1;
    step(1);
    chk("st_fast_req", mem_req, 0);

    // Stray ack in RUN is ignored.
    step(0);
    chk("stray_ack_req", mem_req, 0);
    idle(1);

    // Mispredict pc 0x40: redirect to 0x44, 2 flush cycles, no dequeue.
    head(2'b00, 5'd0, 32'h0, 32'h0, 32'h40, 0, 1, 32'h999);
    step(1);
    chk("mp_redirect", redirect_valid, 1);
    chk("mp_redirect_pc", redirect_pc, 32'h44);
    chk("mp_flush1", flush, 1);
    head(2'b10, 5'd4, 32'h44, 32'h0, 32'h0, 0, 0, 32'h0);
    step(0);
    chk("mp_redirect_once", redirect_valid, 0);
    chk("mp_flush2", flush, 1);
    step(0);
    chk("mp_flush_end", flush, 0);
    step(1);
    chk("mp_after_we", rf_we, 1);

    // Correct branch then ALU: back-to-back dequeues.
    head(2'b00, 5'd0, 32'h0, 32'h0, 32'h60, 1, 1, 32'h80);
    step(1);
    chk("bt_redirect", redirect_valid, 0);
    chk("bt_flush", flush, 0);
    head(2'b10, 5'd6, 32'h66, 32'h0, 32'h0, 0, 0, 32'h0);
    step(1);
    chk("bt_alu_we", rf_we, 1);
    idle(1);

    // Reset during ST_WAIT aborts the store.
    head(2'b01, 5'd0, 32'h5, 32'h300, 32'h0, 0, 0, 32'h0);
    step(0);
    reset = 1; mem_ack = 1;
    step(0);
    chk("rw_mem_req", mem_req, 0);
    chk("rw_count", commit_count, 0);
    reset = 0; mem_ack = 0;
    head(2'b10, 5'd2, 32'h22, 32'h0, 32'h0, 0, 0, 32'h0);
    step(1);
    chk("rw_run_count", commit_count, 1);

    // Reset during FLUSH drops flush at once.
    head(2'b00, 5'd0, 32'h0, 32'h0, 32'h10, 1, 0, 32'h700);
    step(1);
    reset = 1;
    step(0);
    chk("rf_flush", flush, 0);
    reset = 0;
    head(2'b10, 5'd1, 32'h1, 32'h0, 32'h0, 0, 0, 32'h0);
    step(1);

    // Random traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset           = ($urandom_range(0, 49) == 0);
      rob_head_valid  = ($urandom_range(0, 9) < 8);
      rob_head_ready  = ($urandom_range(0, 9) < 7);
      rob_head_itype  = 2'($urandom_range(0, 3));
      rob_head_dest   = 5'($urandom_range(0, 31));
      rob_head_value  = $urandom;
      rob_head_addr   = $urandom;
      rob_head_num    = RW'($urandom_range(0, (1 << RW) - 1));
      rob_head_pc     = $urandom;
      rob_head_taken  = 1'($urandom_range(0, 1));
      rob_head_pred   = 1'($urandom_range(0, 1));
      rob_head_target = $urandom;
      mem_ack         = ($urandom_range(0, 9) < 3);
      step(-1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/commit_unit.md
COMMIT_UNIT -- requirements
Module: commit_unit

Interface
REQ-001 SHALL have parameter FLUSH_CYCLES, default 2, number of cycles flush is held after a mispredict (legal range 1..15).
REQ-002 SHALL have parameter ROB_IDX_W, default 4, width of ROB entry numbers.
REQ-003 SHALL have ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- rob_head_valid  in  1  ROB non-empty.
- rob_head_ready  in  1  head result written back.
- rob_head_itype  in  2  head type: 00 branch, 01 store, 10 ALU, 11 load.
- rob_head_dest  in  5  architectural destination register.
- rob_head_value  in  32  result value; store data for stores.
- rob_head_addr  in  32  store effective address.
- rob_head_num  in  ROB_IDX_W  head ROB entry number.
- rob_head_pc  in  32  instruction PC.
- rob_head_taken  in  1  resolved branch direction.
- rob_head_pred  in  1  predicted branch direction.
- rob_head_target  in  32  resolved branch target.
- mem_ack  in  1  data memory accepted store.
- rob_rd_en  out  1  dequeue ROB head this cycle (combinational).
- rf_we  out  1  register file write strobe.
- rf_waddr  out  5  register file write address.
- rf_wdata  out  32  register file write data.
- rf_wrob  out  ROB_IDX_W  committing ROB number, for rename-table clear.
- mem_req  out  1  store request.
- mem_addr  out  32  store address.
- mem_wdata  out  32  store data.
- redirect_valid  out  1  fetch redirect strobe.
- redirect_pc  out  32  correct-path PC.
- flush  out  1  squash all speculative state.
- commit_count  out  32  retired-instruction counter.

Function
REQ-004 SHALL implement FSM states RUN, ST_WAIT, FLUSH; all outputs except rob_rd_en SHALL be registered.
REQ-005 In RUN, "commit-eligible" SHALL be rob_head_valid & rob_head_ready; otherwise no action, rob_rd_en=0.
REQ-006 ALU/load eligible in RUN: rob_rd_en=1 same cycle; next cycle rf_we=1, rf_waddr=dest, rf_wdata=value, rf_wrob=num, each for exactly one cycle.
REQ-007 dest==0 SHALL suppress rf_we but still dequeue and count.
REQ-008 Branch eligible in RUN: rob_rd_en=1; if taken==pred, no other effect.
REQ-009 Mispredict (taken!=pred): next cycle redirect_valid=1 for one cycle, redirect_pc = taken ? target : pc+4 (mod 2^32); flush=1 for exactly FLUSH_CYCLES cycles starting that same cycle; state -> FLUSH.
REQ-010 In FLUSH rob_rd_en SHALL be 0 and head ignored; after FLUSH_CYCLES cycles state -> RUN, flush deasserted.
REQ-011 Store eligible in RUN: no dequeue; next cycle mem_req=1 with mem_addr=addr, mem_wdata=value; state -> ST_WAIT.
REQ-012 In ST_WAIT mem_req, mem_addr, mem_wdata SHALL hold stable until mem_ack; cycle with mem_ack: rob_rd_en=1; next cycle mem_req=0, state -> RUN.
REQ-013 mem_ack outside ST_WAIT SHALL be ignored; mem_ack in the same cycle mem_req first rises SHALL be accepted.
REQ-014 commit_count SHALL increment by 1 on the edge ending each rob_rd_en=1 cycle, wrapping at 2^32.
REQ-015 At most one dequeue per cycle; the instruction after a committed one is evaluated no earlier than the following cycle.

Reset
REQ-016 reset SHALL force state RUN; rf_we, mem_req, redirect_valid, flush=0; rf_waddr, rf_wdata, rf_wrob, mem_addr, mem_wdata, redirect_pc, commit_count=0; rob_rd_en=0 while reset high.
REQ-017 reset in ST_WAIT or FLUSH SHALL abort: mem_req and flush drop the next cycle, no dequeue, count unchanged.

Verification
REQ-018 ALU head, dest=5, value=0xDEADBEEF, ready=1 -> rob_rd_en same cycle; next cycle rf_we=1, waddr=5, wdata=0xDEADBEEF; count=1.
REQ-019 Load head, dest=0, ready -> rob_rd_en=1, rf_we stays 0, count increments.
REQ-020 Store addr=0x100, data=0x55, mem_ack delayed 3 cycles -> mem_req held 3 cycles with stable addr/data, rob_rd_en only on ack cycle.
REQ-021 Branch pc=0x40, pred=1, taken=0 -> redirect_valid one cycle with redirect_pc=0x44, flush 2 cycles, no dequeue during flush.
REQ-022 Branch pred=taken=1 followed by ready ALU -> two dequeues on consecutive cycles, no redirect, no flush.
REQ-023 reset asserted during ST_WAIT -> mem_req=0 next cycle, state RUN, count=0.
